// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: XLEN, CSR addresses, op/iotrap encodings, mstatus bit positions.
package csr_file_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_ADDRW = 12;

  localparam logic [CSR_ADDRW-1:0] ADDR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDRW-1:0] ADDR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDRW-1:0] ADDR_MEPC    = 12'h341;
  localparam logic [CSR_ADDRW-1:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDRW-1:0] ADDR_MCYCLE  = 12'hB00;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csrOpE;

  typedef enum logic [1:0] {
    IOTRAP_NORMAL = 2'b00,
    IOTRAP_RSVD   = 2'b01,
    IOTRAP_ENTER  = 2'b10,
    IOTRAP_LEAVE  = 2'b11
  } ioTrapE;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  localparam logic [XLEN-1:0] MSTATUS_RESET = XLEN'(32'h0000_1800);

  // Read-modify-write result for a CSR instruction.
  function automatic logic [XLEN-1:0] csrAlu(input logic [1:0] op,
                                             input logic [XLEN-1:0] oldVal,
                                             input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] res;
    res = oldVal;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = oldVal | wdata;
      CSR_OP_CLEAR: res = oldVal & ~wdata;
      default:      res = oldVal;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_mcycle.sv
// Free-running mcycle counter; only compiled when CSR_MCYCLE_EN is defined.
`ifdef CSR_MCYCLE_EN
module csr_mcycle
  import csr_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count
);

  // A CSR write in a cycle replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wrEn) begin
      count <= wdata;
    end else begin
      count <= count + XLEN'(1);
    end
  end

endmodule
`endif

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry/leave sequencing.
// Optional mcycle counter at 0xB00 enabled by defining CSR_MCYCLE_EN.
module csr_file
  import csr_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CSR_ADDRW-1:0] csr_addr,
  input  logic [1:0]           csr_op,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  input  logic                 csrUpdata,
  input  logic [XLEN-1:0]      mcause_n,
  input  logic [XLEN-1:0]      mepc_n,
  input  logic                 mstatus_n,
  input  logic [1:0]           iotrap,
  output logic                 gIntEn,
  output logic                 trap_valid,
  output logic [XLEN-1:0]      trap_pc
);

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic            tflag;

  logic            trapEnter;
  logic            trapLeave;
  logic            trapEvent;
  logic            wrEn;
  logic [XLEN-1:0] newVal;

`ifdef CSR_MCYCLE_EN
  logic [XLEN-1:0] mcycle;

  csr_mcycle uMcycle (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (wrEn && (csr_addr == ADDR_MCYCLE)),
    .wdata (newVal),
    .count (mcycle)
  );
`endif

  assign trapEnter = csrUpdata && (iotrap == IOTRAP_ENTER);
  assign trapLeave = csrUpdata && (iotrap == IOTRAP_LEAVE);
  assign trapEvent = trapEnter || trapLeave;
  assign wrEn      = (csr_op != CSR_OP_NONE);
  assign newVal    = csrAlu(csr_op, csr_rdata, csr_wdata);
  assign gIntEn    = ~tflag;

  // Read mux; unimplemented addresses read zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = mstatus;
      ADDR_MTVEC:   csr_rdata = mtvec;
      ADDR_MEPC:    csr_rdata = mepc;
      ADDR_MCAUSE:  csr_rdata = mcause;
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:  csr_rdata = mcycle;
`endif
      default:      csr_rdata = '0;
    endcase
  end

  // Redirect uses the values held before this edge.
  always_comb begin
    trap_valid = 1'b0;
    trap_pc    = '0;
    if (trapEnter) begin
      trap_valid = 1'b1;
      trap_pc    = mtvec;
    end else if (trapLeave) begin
      trap_valid = 1'b1;
      trap_pc    = mepc;
    end
  end

  // Trap sequencing owns mstatus/mepc/mcause in a trap cycle; mtvec writes always land.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus <= MSTATUS_RESET;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
      tflag   <= 1'b0;
    end else begin
      if (wrEn && (csr_addr == ADDR_MTVEC)) begin
        mtvec <= {newVal[XLEN-1:2], 2'b00};
      end

      if (trapEnter) begin
        mepc                           <= {mepc_n[XLEN-1:1], 1'b0};
        mcause                         <= mcause_n;
        mstatus[MSTATUS_MPIE]          <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]           <= 1'b0;
        mstatus[MSTATUS_MPP_LO +: 2]   <= 2'b11;
      end else if (trapLeave) begin
        mstatus[MSTATUS_MIE]           <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]          <= 1'b1;
      end else if (wrEn) begin
        case (csr_addr)
          ADDR_MSTATUS: mstatus <= newVal;
          ADDR_MEPC:    mepc    <= {newVal[XLEN-1:1], 1'b0};
          ADDR_MCAUSE:  mcause  <= newVal;
          default: ;
        endcase
      end

      if (trapEvent) begin
        tflag <= mstatus_n;
      end
    end
  end

endmodule
